// File: rtl/vip_pkg.sv
// Shared constants and Bayer-phase helpers for the RGB888 -> RAW8 video path.
// Phase encoding, counter width and default frame geometry live here.
package vip_pkg;

  typedef enum logic [1:0] {
    BGGR = 2'b00,
    GBRG = 2'b01,
    GRBG = 2'b10,
    RGGB = 2'b11
  } bayer_t;

  typedef enum logic [1:0] {
    SITE_B = 2'd0,
    SITE_G = 2'd1,
    SITE_R = 2'd2
  } site_t;

  localparam int CNT_W         = 14;
  localparam int IMG_HDISP_DEF = 640;
  localparam int IMG_VDISP_DEF = 480;

  // mirror[0] shifts the pattern by one column, mirror[1] by one row
  function automatic site_t bayer_site(
    input bayer_t ph,
    input logic   row,
    input logic   col
  );
    logic  r;
    logic  c;
    site_t s;
    r = row ^ ph[1];
    c = col ^ ph[0];
    s = SITE_G;
    unique case (1'b1)
      (!r && !c): s = SITE_B;
      (r && c):   s = SITE_R;
      default:    s = SITE_G;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/vip_frame_chk.sv
// Frame geometry checker: counts href-high cycles per line and lines per
// frame, raising sticky flags aligned with the 2-clk video pipeline.
module vip_frame_chk
  import vip_pkg::*;
#(
  parameter int IMG_HDISP = IMG_HDISP_DEF,
  parameter int IMG_VDISP = IMG_VDISP_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic vsync,
  input  logic href,
  output logic err_hsize,
  output logic err_vsize
);

  localparam logic [CNT_W-1:0] H_EXP   = CNT_W'(IMG_HDISP);
  localparam logic [CNT_W-1:0] V_EXP   = CNT_W'(IMG_VDISP);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             vs_q;
  logic             href_q;
  logic             armed;
  logic [CNT_W-1:0] pix_cnt;
  logic [CNT_W-1:0] line_cnt;
  logic             eh1;
  logic             ev1;
  logic             eh2;
  logic             ev2;
  logic             vs_fall;
  logic             href_fall;

  assign vs_fall   = vs_q & ~vsync;
  assign href_fall = href_q & ~href;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vs_q     <= 1'b1;
      href_q   <= 1'b0;
      armed    <= 1'b0;
      pix_cnt  <= '0;
      line_cnt <= '0;
      eh1      <= 1'b0;
      ev1      <= 1'b0;
      eh2      <= 1'b0;
      ev2      <= 1'b0;
    end else begin
      vs_q   <= vsync;
      href_q <= href;
      if (!href)
        pix_cnt <= '0;
      else if (pix_cnt != CNT_MAX)
        pix_cnt <= pix_cnt + 1'b1;
      if (!vsync)
        line_cnt <= '0;
      else if (href_fall && line_cnt != CNT_MAX)
        line_cnt <= line_cnt + 1'b1;
      // first vsync fall after reset only arms; the partial frame is ignored
      if (vs_fall)
        armed <= 1'b1;
      eh1 <= eh1 | (armed & href_fall & (pix_cnt != H_EXP));
      ev1 <= ev1 | (armed & vs_fall & (line_cnt != V_EXP));
      eh2 <= eh1;
      ev2 <= ev1;
    end
  end

  assign err_hsize = eh2;
  assign err_vsize = ev2;

endmodule

// File: rtl/vip_rgb888_raw8.sv
// RGB888 -> RAW8 Bayer re-mosaic with a fixed 2-clk pipeline.
// Define VIP_RGB2RAW_FRAME_CHK_EN to build the frame geometry checker.
module vip_rgb888_raw8
  import vip_pkg::*;
#(
  parameter int IMG_HDISP = IMG_HDISP_DEF,
  parameter int IMG_VDISP = IMG_VDISP_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] mirror,
  input  logic       per_frame_vsync,
  input  logic       per_frame_hsync,
  input  logic       per_frame_href,
  input  logic [7:0] per_img_red,
  input  logic [7:0] per_img_green,
  input  logic [7:0] per_img_blue,
  output logic       post_frame_vsync,
  output logic       post_frame_hsync,
  output logic       post_frame_href,
  output logic [7:0] post_img_RAW,
  output logic       err_hsize,
  output logic       err_vsize
);

  if (IMG_HDISP < 1 || IMG_VDISP < 1) begin : g_bad_geom
    $error("vip_rgb888_raw8: frame geometry must be non-zero");
  end

  logic       vs_q;
  logic       href_q;
  logic       row_q;
  logic       col_q;
  bayer_t     mir_q;
  logic       vs_fall;
  logic       href_fall;
  logic       row_e;
  logic       col_e;
  site_t      site;
  logic [7:0] pix;
  logic       vs1;
  logic       hs1;
  logic       href1;
  logic [7:0] raw1;
  logic       vs2;
  logic       hs2;
  logic       href2;
  logic [7:0] raw2;

  assign vs_fall   = vs_q & ~per_frame_vsync;
  assign href_fall = href_q & ~per_frame_href;
  // parity clears in the very cycle vsync drops, even mid-line
  assign row_e     = per_frame_vsync & row_q;
  assign col_e     = col_q & ~vs_fall;
  assign site      = bayer_site(mir_q, row_e, col_e);

  always_comb begin
    pix = per_img_green;
    case (site)
      SITE_B:  pix = per_img_blue;
      SITE_R:  pix = per_img_red;
      default: pix = per_img_green;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vs_q   <= 1'b1;
      href_q <= 1'b0;
      row_q  <= 1'b0;
      col_q  <= 1'b0;
      mir_q  <= BGGR;
      vs1    <= 1'b1;
      hs1    <= 1'b1;
      href1  <= 1'b0;
      raw1   <= '0;
      vs2    <= 1'b1;
      hs2    <= 1'b1;
      href2  <= 1'b0;
      raw2   <= '0;
    end else begin
      vs_q   <= per_frame_vsync;
      href_q <= per_frame_href;
      col_q  <= per_frame_href & ~col_e;
      row_q  <= per_frame_vsync & (row_q ^ href_fall);
      if (vs_fall)
        mir_q <= bayer_t'(mirror);
      vs1    <= per_frame_vsync;
      hs1    <= per_frame_hsync;
      href1  <= per_frame_href;
      raw1   <= per_frame_href ? pix : 8'd0;
      vs2    <= vs1;
      hs2    <= hs1;
      href2  <= href1;
      raw2   <= raw1;
    end
  end

  assign post_frame_vsync = vs2;
  assign post_frame_hsync = hs2;
  assign post_frame_href  = href2;
  assign post_img_RAW     = raw2;

`ifdef VIP_RGB2RAW_FRAME_CHK_EN
  vip_frame_chk #(
    .IMG_HDISP (IMG_HDISP),
    .IMG_VDISP (IMG_VDISP)
  ) u_frame_chk (
    .clk       (clk),
    .rst       (rst),
    .vsync     (per_frame_vsync),
    .href      (per_frame_href),
    .err_hsize (err_hsize),
    .err_vsize (err_vsize)
  );
`else
  assign err_hsize = 1'b0;
  assign err_vsize = 1'b0;
`endif

endmodule

// File: tb/tb_vip_rgb888_raw8.sv
// Bench for vip_rgb888_raw8: directed frame sequences with random pixels,
// checked every cycle against a row/column position model.
module tb_vip_rgb888_raw8;

  localparam int H = 16;
  localparam int V = 6;

  typedef struct packed {
    logic       vs;
    logic       hs;
    logic       hr;
    logic [7:0] raw;
    logic       eh;
    logic       ev;
  } exp_t;

  logic       clk;
  logic       rst;
  logic [1:0] mirror;
  logic       per_frame_vsync;
  logic       per_frame_hsync;
  logic       per_frame_href;
  logic [7:0] per_img_red;
  logic [7:0] per_img_green;
  logic [7:0] per_img_blue;
  logic       post_frame_vsync;
  logic       post_frame_hsync;
  logic       post_frame_href;
  logic [7:0] post_img_RAW;
  logic       err_hsize;
  logic       err_vsize;

  vip_rgb888_raw8 #(
    .IMG_HDISP (H),
    .IMG_VDISP (V)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .mirror           (mirror),
    .per_frame_vsync  (per_frame_vsync),
    .per_frame_hsync  (per_frame_hsync),
    .per_frame_href   (per_frame_href),
    .per_img_red      (per_img_red),
    .per_img_green    (per_img_green),
    .per_img_blue     (per_img_blue),
    .post_frame_vsync (post_frame_vsync),
    .post_frame_hsync (post_frame_hsync),
    .post_frame_href  (post_frame_href),
    .post_img_RAW     (post_img_RAW),
    .err_hsize        (err_hsize),
    .err_vsize        (err_vsize)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int         tests;
  int         fails;
  logic       cur_vs;
  logic [1:0] cur_m;
  logic       const_rgb;

  // reference model state: position in frame, not RTL parity bits
  logic       m_prev_vs;
  logic       m_prev_hr;
  int         m_line;
  int         m_pix;
  int         m_hcnt;
  logic [1:0] m_mir;
  logic       m_armed;
  logic       m_eh;
  logic       m_ev;
  exp_t       exp1;
  exp_t       exp2;
  exp_t       rst_val;

  task automatic model_reset();
    m_prev_vs = 1'b1;
    m_prev_hr = 1'b0;
    m_line    = 0;
    m_pix     = 0;
    m_hcnt    = 0;
    m_mir     = 2'b00;
    m_armed   = 1'b0;
    m_eh      = 1'b0;
    m_ev      = 1'b0;
    exp1      = rst_val;
    exp2      = rst_val;
  endtask

  task automatic chk(input exp_t e);
    tests++;
    assert ({post_frame_vsync, post_frame_hsync, post_frame_href} ===
            {e.vs, e.hs, e.hr})
    else begin
      fails++;
      $error("FAIL sync @%0t observed=%b expected=%b", $time,
             {post_frame_vsync, post_frame_hsync, post_frame_href},
             {e.vs, e.hs, e.hr});
    end
    tests++;
    assert (post_img_RAW === e.raw)
    else begin
      fails++;
      $error("FAIL raw @%0t observed=%0d expected=%0d", $time,
             post_img_RAW, e.raw);
    end
    tests++;
    assert ({err_hsize, err_vsize} === {e.eh, e.ev})
    else begin
      fails++;
      $error("FAIL err @%0t observed=%b expected=%b", $time,
             {err_hsize, err_vsize}, {e.eh, e.ev});
    end
  endtask

  task automatic cyc(input logic hs, input logic hr);
    exp_t       e;
    logic       vf;
    logic       hf;
    logic       rr;
    logic       cc;
    int         ln;
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    logic [7:0] v;
    r = 8'($urandom);
    g = 8'($urandom);
    b = 8'($urandom);
    if (const_rgb) begin
      r = 8'd200;
      g = 8'd150;
      b = 8'd100;
    end
    per_frame_vsync = cur_vs;
    per_frame_hsync = hs;
    per_frame_href  = hr;
    per_img_red     = r;
    per_img_green   = g;
    per_img_blue    = b;
    mirror          = cur_m;
    vf = m_prev_vs && !cur_vs;
    hf = m_prev_hr && !hr;
    m_pix = (!m_prev_hr || vf) ? 0 : m_pix + 1;
    ln = cur_vs ? m_line : 0;
    rr = ln[0] ^ m_mir[1];
    cc = m_pix[0] ^ m_mir[0];
    if (!rr && !cc) v = b;
    else if (rr && cc) v = r;
    else v = g;
    if (hf && m_armed && m_hcnt != H) m_eh = 1'b1;
    if (vf && m_armed && m_line != V) m_ev = 1'b1;
    m_hcnt = hr ? m_hcnt + 1 : 0;
    m_line = !cur_vs ? 0 : m_line + (hf ? 1 : 0);
    if (vf) begin
      m_armed = 1'b1;
      m_mir   = cur_m;
    end
    e.vs  = cur_vs;
    e.hs  = hs;
    e.hr  = hr;
    e.raw = hr ? v : 8'd0;
`ifdef VIP_RGB2RAW_FRAME_CHK_EN
    e.eh  = m_eh;
    e.ev  = m_ev;
`else
    e.eh  = 1'b0;
    e.ev  = 1'b0;
`endif
    m_prev_vs = cur_vs;
    m_prev_hr = hr;
    @(posedge clk);
    exp2 = exp1;
    exp1 = e;
    #1;
    chk(exp2);
  endtask

  task automatic line(input int n, input int drop);
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);
    cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b0);
    for (int i = 0; i < n; i++) begin
      if (i == drop) cur_vs = 1'b0;
      cyc(1'b1, 1'b1);
    end
    repeat (3) cyc(1'b1, 1'b0);
  endtask

  task automatic frame_start();
    cur_vs = 1'b0;
    repeat (3) cyc(1'b1, 1'b0);
    cur_vs = 1'b1;
    repeat (2) cyc(1'b1, 1'b0);
  endtask

  task automatic frame(input int nl, input logic [1:0] m);
    cur_m = m;
    frame_start();
    for (int l = 0; l < nl; l++) line(H, -1);
  endtask

  task automatic do_reset();
    #2;
    rst             = 1'b1;
    per_frame_vsync = 1'b1;
    per_frame_hsync = 1'b1;
    per_frame_href  = 1'b0;
    cur_vs          = 1'b1;
    #1;
    tests++;
    assert ({post_frame_vsync, post_frame_hsync, post_frame_href,
             post_img_RAW, err_hsize, err_vsize} === 13'b1_1_0_00000000_0_0)
    else begin
      fails++;
      $error("FAIL reset_async observed=%b expected=%b",
             {post_frame_vsync, post_frame_hsync, post_frame_href,
              post_img_RAW, err_hsize, err_vsize}, 13'b1_1_0_00000000_0_0);
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    tests     = 0;
    fails     = 0;
    rst_val   = '{vs: 1'b1, hs: 1'b1, hr: 1'b0, raw: 8'd0,
                  eh: 1'b0, ev: 1'b0};
    rst       = 1'b1;
    cur_vs    = 1'b1;
    cur_m     = 2'b00;
    const_rgb = 1'b1;
    mirror          = 2'b00;
    per_frame_vsync = 1'b1;
    per_frame_hsync = 1'b1;
    per_frame_href  = 1'b0;
    per_img_red     = 8'd0;
    per_img_green   = 8'd0;
    per_img_blue    = 8'd0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk(rst_val);
    rst = 1'b0;

    // constant colour, BGGR then RGGB
    frame(V, 2'b00);
    frame(V, 2'b11);

    // random pixels, every phase
    const_rgb = 1'b0;
    frame(V, 2'b01);
    frame(V, 2'b10);
    frame(V, 2'($urandom));

    // mirror change mid-frame only lands on the next frame
    cur_m = 2'b00;
    frame_start();
    for (int l = 0; l < V; l++) begin
      if (l == V / 2) cur_m = 2'b11;
      line(H, -1);
    end
    frame(V, 2'b01);

    // reset mid-line, partial frame, then a clean frame
    cyc(1'b0, 1'b0);
    cyc(1'b1, 1'b0);
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1);
    do_reset();
    line(H - 3, -1);
    line(H - 5, -1);
    frame(V, 2'b10);
    frame(V, 2'b00);

    // short line, then short frame
    cur_m = 2'b00;
    frame_start();
    line(H, -1);
    line(H - 1, -1);
    for (int l = 2; l < V; l++) line(H, -1);
    frame(V - 1, 2'b11);
    frame(V, 2'b00);
    repeat (4) cyc(1'b1, 1'b0);

    // vsync pulled low inside row 1
    do_reset();
    frame(V, 2'b00);
    cur_m = 2'b00;
    frame_start();
    line(H, -1);
    line(H, 9);
    repeat (2) cyc(1'b1, 1'b0);
    cur_vs = 1'b1;
    repeat (2) cyc(1'b1, 1'b0);
    for (int l = 0; l < V; l++) line(H, -1);
    frame(V, 2'b00);
    repeat (4) cyc(1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
